// File: rtl/game_master_fsm_multi_shot_pkg.sv
// Shared configuration for the multi-shot game master.
// Holds the 2-bit FSM state encodings, the parameter defaults used by the top
// level, and the fixed round counter width.
package game_master_fsm_multi_shot_pkg;

    // Parameter defaults
    localparam int unsigned DefNTorpedoes = 3;
    localparam int unsigned DefNRounds    = 5;
    localparam int unsigned DefScoreW     = 4;

    // Round counter is fixed at 4 bits, enough for up to 15 rounds
    localparam int unsigned RoundW = 4;

    // FSM state encodings
    localparam logic [1:0] StStart = 2'd0;
    localparam logic [1:0] StPlay  = 2'd1;
    localparam logic [1:0] StEnd   = 2'd2;
    localparam logic [1:0] StOver  = 2'd3;

endpackage

// File: rtl/game_master_fsm_multi_shot_key_edge.sv
// Rising-edge detector for the fire / restart key.
// Ports:
//   clk_i       system clock
//   reset_i     asynchronous active-high reset
//   key_i       key level, already synchronised
//   key_edge_o  registered one-cycle pulse on each rising edge of key_i
module game_master_fsm_multi_shot_key_edge (
    input  logic clk_i,
    input  logic reset_i,
    input  logic key_i,
    output logic key_edge_o
);

    logic key_q;
    logic edge_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            key_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            key_q  <= key_i;
            edge_q <= key_i & ~key_q;
        end
    end

    assign key_edge_o = edge_q;

endmodule

// File: rtl/game_master_fsm_multi_shot.sv
// Game master FSM for one target sprite and N_TORPEDOES torpedo sprites.
// Each round the player may fire a salvo of up to N_TORPEDOES shots; a hit
// on the target wins the round, the target or the whole salvo leaving the
// screen loses it. A saturating score is kept across N_ROUNDS rounds, after
// which the FSM holds in OVER until a fresh key press.
// Ports:
//   clk_i, reset_i                      clock, async active-high reset
//   key_i                               fire / restart key (level)
//   sprite_target_*_o                   target sprite write / update controls
//   sprite_torpedo_*_o                  per-torpedo write / update controls
//   sprite_target_within_screen_i       target still visible
//   sprite_torpedo_within_screen_i      per-torpedo still visible
//   collision_i                         torpedo[i] overlaps target
//   end_of_game_timer_start_o           one-cycle timer start pulse
//   end_of_game_timer_running_i         timer busy
//   game_won_o, score_o, game_over_o    round result, score, game over flag
module game_master_fsm_multi_shot
    import game_master_fsm_multi_shot_pkg::*;
#(
    parameter int unsigned N_TORPEDOES = DefNTorpedoes,
    parameter int unsigned N_ROUNDS    = DefNRounds,
    parameter int unsigned SCORE_W     = DefScoreW
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   key_i,
    output logic                   sprite_target_write_xy_o,
    output logic                   sprite_target_write_dxy_o,
    output logic                   sprite_target_enable_update_o,
    output logic [N_TORPEDOES-1:0] sprite_torpedo_write_xy_o,
    output logic [N_TORPEDOES-1:0] sprite_torpedo_write_dxy_o,
    output logic [N_TORPEDOES-1:0] sprite_torpedo_enable_update_o,
    input  logic                   sprite_target_within_screen_i,
    input  logic [N_TORPEDOES-1:0] sprite_torpedo_within_screen_i,
    input  logic [N_TORPEDOES-1:0] collision_i,
    output logic                   end_of_game_timer_start_o,
    input  logic                   end_of_game_timer_running_i,
    output logic                   game_won_o,
    output logic [SCORE_W-1:0]     score_o,
    output logic                   game_over_o
);

    localparam int unsigned ShotW = $clog2(N_TORPEDOES + 1);
    localparam logic [ShotW-1:0]   ShotMax   = ShotW'(N_TORPEDOES);
    localparam logic [SCORE_W-1:0] ScoreMax  = '1;
    localparam logic [RoundW-1:0]  LastRound = RoundW'(N_ROUNDS - 1);

    logic key_edge;

    game_master_fsm_multi_shot_key_edge u_key_edge (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .key_i      (key_i),
        .key_edge_o (key_edge)
    );

    logic [1:0]             state_q, state_d;
    logic [N_TORPEDOES-1:0] in_flight_q, in_flight_d;
    logic [ShotW-1:0]       shot_q, shot_d;
    logic [RoundW-1:0]      round_q, round_d;
    logic [SCORE_W-1:0]     score_q, score_d;
    logic                   won_q, won_d;
    logic                   end_first_q, end_first_d;

    logic                   tgt_xy_q, tgt_xy_d;
    logic                   tgt_dxy_q, tgt_dxy_d;
    logic                   tgt_en_q, tgt_en_d;
    logic [N_TORPEDOES-1:0] tor_xy_q, tor_xy_d;
    logic [N_TORPEDOES-1:0] tor_dxy_q, tor_dxy_d;
    logic [N_TORPEDOES-1:0] tor_en_q, tor_en_d;
    logic                   timer_start_q, timer_start_d;
    logic                   over_q, over_d;

    logic [N_TORPEDOES-1:0] in_flight_kept;
    logic [N_TORPEDOES-1:0] launch_mask;
    logic                   in_play;
    logic                   hit;
    logic                   lost;
    logic                   launch;

    // Round outcome decode; hit and lost take precedence over a launch
    always_comb begin
        in_play        = (state_q == StPlay);
        in_flight_kept = in_flight_q & sprite_torpedo_within_screen_i;
        launch_mask    = N_TORPEDOES'(1) << shot_q;
        hit            = in_play && |(collision_i & in_flight_q);
        lost           = in_play && (!sprite_target_within_screen_i ||
                         ((shot_q == ShotMax) && (in_flight_kept == '0)));
        launch         = in_play && key_edge && (shot_q < ShotMax) && !hit && !lost;
    end

    // Next state, counters and next output values
    always_comb begin
        state_d       = state_q;
        in_flight_d   = in_flight_q;
        shot_d        = shot_q;
        round_d       = round_q;
        score_d       = score_q;
        won_d         = won_q;
        end_first_d   = 1'b0;
        tgt_xy_d      = 1'b0;
        tgt_dxy_d     = 1'b0;
        tor_xy_d      = '0;
        tor_dxy_d     = '0;
        timer_start_d = 1'b0;

        case (state_q)
            StStart: begin
                tgt_xy_d    = 1'b1;
                tgt_dxy_d   = 1'b1;
                tor_xy_d    = '1;
                in_flight_d = '0;
                shot_d      = '0;
                won_d       = 1'b0;
                state_d     = StPlay;
            end
            StPlay: begin
                in_flight_d = in_flight_kept;
                if (hit) begin
                    won_d         = 1'b1;
                    score_d       = (score_q == ScoreMax) ? score_q : score_q + SCORE_W'(1);
                    timer_start_d = 1'b1;
                    end_first_d   = 1'b1;
                    state_d       = StEnd;
                end else if (lost) begin
                    timer_start_d = 1'b1;
                    end_first_d   = 1'b1;
                    state_d       = StEnd;
                end else if (launch) begin
                    tor_dxy_d   = launch_mask;
                    in_flight_d = in_flight_kept | launch_mask;
                    shot_d      = shot_q + ShotW'(1);
                end
            end
            StEnd: begin
                // The first END cycle ignores timer_running: the timer has
                // not yet seen its start pulse.
                if (!end_first_q && !end_of_game_timer_running_i) begin
                    round_d = round_q + RoundW'(1);
                    state_d = (round_q == LastRound) ? StOver : StStart;
                end
            end
            StOver: begin
                if (key_edge) begin
                    score_d = '0;
                    round_d = '0;
                    state_d = StStart;
                end
            end
            default: state_d = StStart;
        endcase

        // Level outputs follow the state being entered so they line up with state_q
        tgt_en_d = (state_d == StPlay);
        tor_en_d = (state_d == StPlay) ? in_flight_d : '0;
        over_d   = (state_d == StOver);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StStart;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            in_flight_q   <= '0;
            shot_q        <= '0;
            round_q       <= '0;
            score_q       <= '0;
            won_q         <= 1'b0;
            end_first_q   <= 1'b0;
            tgt_xy_q      <= 1'b0;
            tgt_dxy_q     <= 1'b0;
            tgt_en_q      <= 1'b0;
            tor_xy_q      <= '0;
            tor_dxy_q     <= '0;
            tor_en_q      <= '0;
            timer_start_q <= 1'b0;
            over_q        <= 1'b0;
        end else begin
            in_flight_q   <= in_flight_d;
            shot_q        <= shot_d;
            round_q       <= round_d;
            score_q       <= score_d;
            won_q         <= won_d;
            end_first_q   <= end_first_d;
            tgt_xy_q      <= tgt_xy_d;
            tgt_dxy_q     <= tgt_dxy_d;
            tgt_en_q      <= tgt_en_d;
            tor_xy_q      <= tor_xy_d;
            tor_dxy_q     <= tor_dxy_d;
            tor_en_q      <= tor_en_d;
            timer_start_q <= timer_start_d;
            over_q        <= over_d;
        end
    end

    assign sprite_target_write_xy_o       = tgt_xy_q;
    assign sprite_target_write_dxy_o      = tgt_dxy_q;
    assign sprite_target_enable_update_o  = tgt_en_q;
    assign sprite_torpedo_write_xy_o      = tor_xy_q;
    assign sprite_torpedo_write_dxy_o     = tor_dxy_q;
    assign sprite_torpedo_enable_update_o = tor_en_q;
    assign end_of_game_timer_start_o      = timer_start_q;
    assign game_won_o                     = won_q;
    assign score_o                        = score_q;
    assign game_over_o                    = over_q;

endmodule
